// File: rtl/eth_tx_frame_mux.sv
// rtl/eth_tx_frame_mux.sv - N-channel round-robin frame mux onto one 8-bit MAC TX stream
// Whole-frame grants, per-byte source tag, oversize frames truncated with an error mark.
module eth_tx_frame_mux #(
  parameter int CHANNELS         = 4,
  parameter int MAX_FRAME_LENGTH = 1514,
  parameter int COUNT_WIDTH      = 16,
  parameter int ID_WIDTH         = $clog2(CHANNELS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS*8-1:0]           s_axis_tdata,
  input  logic [CHANNELS-1:0]             s_axis_tvalid,
  input  logic [CHANNELS-1:0]             s_axis_tlast,
  input  logic [CHANNELS-1:0]             s_axis_tuser,
  output logic [CHANNELS-1:0]             s_axis_tready,
  output logic [7:0]                      m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  input  logic                            m_axis_tready,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  input  logic [CHANNELS-1:0]             enable,
  output logic                            busy,
  output logic [CHANNELS*COUNT_WIDTH-1:0] frame_count,
  output logic [CHANNELS*COUNT_WIDTH-1:0] trunc_count
);

  localparam int CNT_W = $clog2(MAX_FRAME_LENGTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_FRAME_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     sel;
  logic [ID_WIDTH-1:0]     last_grant;
  logic [CNT_W-1:0]        byte_cnt;
  logic [COUNT_WIDTH-1:0]  fcnt [CHANNELS];
  logic [COUNT_WIDTH-1:0]  tcnt [CHANNELS];
  logic [7:0]              in_data [CHANNELS];

  logic                    grant_ok;
  logic [ID_WIDTH-1:0]     grant_idx;
  logic [ID_WIDTH-1:0]     scan_idx;
  logic [CHANNELS-1:0]     req;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_user;
  logic                    out_ready;
  logic                    beat;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign in_data[g] = s_axis_tdata[g*8 +: 8];
    assign frame_count[g*COUNT_WIDTH +: COUNT_WIDTH] = fcnt[g];
    assign trunc_count[g*COUNT_WIDTH +: COUNT_WIDTH] = tcnt[g];
  end

  assign req       = s_axis_tvalid & enable;
  assign in_valid  = s_axis_tvalid[sel];
  assign in_last   = s_axis_tlast[sel];
  assign in_user   = s_axis_tuser[sel];
  assign out_ready = !m_axis_tvalid || m_axis_tready;
  assign beat      = (state == XFER) && in_valid && out_ready;
  assign busy      = (state != IDLE);

  // Scan from the farthest candidate down so the nearest one after last_grant wins.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      scan_idx = ID_WIDTH'((int'(last_grant) + i) % CHANNELS);
      if (req[scan_idx]) begin
        grant_ok  = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (state == XFER) s_axis_tready[sel] = out_ready;
    else if (state == DROP) s_axis_tready[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel           <= '0;
      last_grant    <= ID_WIDTH'(CHANNELS - 1);
      byte_cnt      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tid    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        fcnt[i] <= '0;
        tcnt[i] <= '0;
      end
    end else begin
      if (m_axis_tready) m_axis_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            sel      <= grant_idx;
            byte_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= in_data[sel];
            m_axis_tid    <= sel;
            byte_cnt      <= byte_cnt + 1'b1;
            if (in_last) begin
              m_axis_tlast <= 1'b1;
              m_axis_tuser <= in_user;
              fcnt[sel]    <= fcnt[sel] + 1'b1;
              last_grant   <= sel;
              state        <= IDLE;
            end else if (byte_cnt == LAST_IDX) begin
              // Oversize: close the frame here with an error mark, swallow the rest.
              m_axis_tlast <= 1'b1;
              m_axis_tuser <= 1'b1;
              tcnt[sel]    <= tcnt[sel] + 1'b1;
              last_grant   <= sel;
              state        <= DROP;
            end else begin
              m_axis_tlast <= 1'b0;
              m_axis_tuser <= in_user;
            end
          end
        end
        DROP: begin
          if (in_valid && in_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
